// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data RAM between the CPU data port and a debug/loader port.
// Accesses are serialised by an IDLE -> ACCESS -> DONE FSM with round-robin priority.
// Each access holds the RAM for RAM_LATENCY cycles, and the winner gets a one-cycle ack.
// Optional feature macro: MEM_ARB_LOCK_EN adds dbg_lock. While it is high, IDLE does not
// grant CPU requests.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them until it
// sees a one-cycle ack. On a read ack, rdata is valid in that cycle and is held until
// that port's next read ack.
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic          dbg_lock,
`endif
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter value that marks the last ACCESS cycle.
    localparam logic [3:0] LAST_CNT = 4'(RAM_LATENCY - 1);

    state_t     state_q;
    logic       prio_dbg;   // 0: CPU holds priority, 1: debug holds priority
    logic       win_dbg;    // port that owns the current access
    logic       win_we;     // current access is a write
    logic [3:0] lat_cnt;
    logic       lock;
    logic       cpu_eligible;
    logic       pick_dbg;

`ifdef MEM_ARB_LOCK_EN
    assign lock = dbg_lock;
`else
    assign lock = 1'b0;
`endif

    // A CPU request that is locked out behaves as if it were absent for arbitration.
    assign cpu_eligible = cpu_req & ~lock;
    assign pick_dbg     = dbg_req & (~cpu_eligible | prio_dbg);
    assign cpu_stall    = cpu_req & ~cpu_ack;
    assign fsm_state    = state_q;

    // Arbitration FSM: grant in IDLE, drive RAM in ACCESS, ack and rotate priority in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_dbg  <= 1'b0;
            win_dbg   <= 1'b0;
            win_we    <= 1'b0;
            lat_cnt   <= 4'd0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_eligible || dbg_req) begin
                        win_dbg   <= pick_dbg;
                        win_we    <= pick_dbg ? dbg_we : cpu_we;
                        ram_we    <= pick_dbg ? dbg_we : cpu_we;
                        ram_addr  <= pick_dbg ? dbg_addr : cpu_addr;
                        ram_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
                        lat_cnt   <= 4'd0;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The write strobe covers only the first ACCESS cycle.
                    ram_we <= 1'b0;
                    if (lat_cnt == LAST_CNT) begin
                        if (!win_we) begin
                            if (win_dbg) dbg_rdata <= ram_rdata;
                            else         cpu_rdata <= ram_rdata;
                        end
                        if (win_dbg) dbg_ack <= 1'b1;
                        else         cpu_ack <= 1'b1;
                        lat_cnt <= 4'd0;
                        state_q <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                DONE: begin
                    cpu_ack  <= 1'b0;
                    dbg_ack  <= 1'b0;
                    prio_dbg <= ~win_dbg;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// It uses one instance with RAM_LATENCY=1 and one with RAM_LATENCY=3.
// A behavioural RAM array serves both instances. Lock tests are built only with MEM_ARB_LOCK_EN.
module tb_mem_arbiter;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Latency-1 instance signals
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [1:0]  fsm_state;
`ifdef MEM_ARB_LOCK_EN
    logic        dbg_lock;
`endif

    // Latency-3 instance signals
    logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_cpu_stall;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic        b_dbg_req, b_dbg_we, b_dbg_ack;
    logic [31:0] b_dbg_addr, b_dbg_wdata, b_dbg_rdata;
    logic        b_ram_we;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic [1:0]  b_fsm_state;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
`ifdef MEM_ARB_LOCK_EN
        .dbg_lock(dbg_lock),
`endif
        .fsm_state(fsm_state)
    );

    mem_arbiter #(.RAM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
        .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
`ifdef MEM_ARB_LOCK_EN
        .dbg_lock(1'b0),
`endif
        .fsm_state(b_fsm_state)
    );

    // Behavioural RAM. It is word indexed and writable only by the latency-1 instance or by preload.
    logic [31:0] mem [16];
    logic        load_en;
    logic [3:0]  load_idx;
    logic [31:0] load_data;
    assign ram_rdata   = mem[ram_addr[5:2]];
    assign b_ram_rdata = mem[b_ram_addr[5:2]];
    always @(posedge clk) begin
        if (load_en)     mem[load_idx] <= load_data;
        else if (ram_we) mem[ram_addr[5:2]] <= ram_wdata;
    end

    // Event counters sampled on the falling edge
    int ram_we_cnt   = 0;
    int both_ack_cnt = 0;
    int cpu_ack_cnt  = 0;
    always @(negedge clk) begin
        if (ram_we) ram_we_cnt++;
        if (cpu_ack && dbg_ack) both_ack_cnt++;
        if (cpu_ack) cpu_ack_cnt++;
    end

    // Scoreboard counters
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Driver task for the latency-1 instance. port 0 is the CPU and port 1 is debug.
    // lat is the number of cycles from the request cycle to the ack cycle.
    task automatic do_access(input bit port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rd, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        rd   = '0;
        if (port) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if ((port && dbg_ack) || (!port && cpu_ack)) begin
                seen = 1'b1;
                lat  = n;
                rd   = port ? dbg_rdata : cpu_rdata;
            end
        end
        check(port ? "dbg_ack_seen" : "cpu_ack_seen", {31'b0, seen}, 32'd1);
        @(posedge clk); #1;
        if (port) dbg_req = 1'b0;
        else      cpu_req = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        logic [31:0] rd;
        int lat, w0, a0, cpu_n, dbg_n;
        bit seen;

        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_dbg_req = 0; b_dbg_we = 0; b_dbg_addr = 0; b_dbg_wdata = 0;
`ifdef MEM_ARB_LOCK_EN
        dbg_lock = 1'b0;
`endif
        load_en = 1'b1; load_idx = 4'd4; load_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        load_en = 1'b0;
        @(posedge clk); #1;

        // Reset values
        @(negedge clk);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_dbg_ack", dbg_ack, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_state", fsm_state, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: uncontended CPU read with latency 1
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        @(negedge clk);
        check("t1_stall_t", cpu_stall, 1);
        check("t1_noack_t", cpu_ack, 0);
        @(negedge clk);
        check("t1_ram_addr", ram_addr, 32'h10);
        check("t1_ram_we", ram_we, 0);
        check("t1_stall_t1", cpu_stall, 1);
        check("t1_state_access", fsm_state, 1);
        @(negedge clk);
        check("t1_ack", cpu_ack, 1);
        check("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t1_stall_ack", cpu_stall, 0);
        @(posedge clk); #1;
        cpu_req = 1'b0;

        // 2: debug write, then CPU read-back
        w0 = ram_we_cnt;
        do_access(1'b1, 1'b1, 32'h20, 32'h12345678, rd, lat);
        check("t2_ram_we_pulses", ram_we_cnt - w0, 1);
        check("t2_dbg_latency", lat, 2);
        do_access(1'b0, 1'b0, 32'h20, 32'h0, rd, lat);
        check("t2_cpu_rdata", rd, 32'h12345678);
        check("t2_dbg_rdata_kept", dbg_rdata, 0);

        // 3: continuous contention must alternate, starting with the CPU
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i % 2));
        w0 = both_ack_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        for (int n = 0; n < 200 && got_q.size() < 8; n++) begin
            @(negedge clk);
            if (cpu_ack) got_q.push_back(32'd0);
            if (dbg_ack) got_q.push_back(32'd1);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("t3_ack_count", got_q.size(), 8);
        while (exp_q.size() > 0 && got_q.size() > 0)
            check("t3_ack_order", got_q.pop_front(), exp_q.pop_front());
        check("t3_no_double_ack", both_ack_cnt - w0, 0);

        // 4: latency-3 instance, CPU and debug requesting in the same cycle
        cpu_n = -1; dbg_n = -1;
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h10;
        b_dbg_req = 1'b1; b_dbg_we = 1'b0; b_dbg_addr = 32'h20;
        for (int n = 0; n < 30 && dbg_n < 0; n++) begin
            @(negedge clk);
            if (b_cpu_ack) begin cpu_n = n; b_cpu_req = 1'b0; end
            if (b_dbg_ack) begin dbg_n = n; b_dbg_req = 1'b0; end
        end
        b_cpu_req = 1'b0; b_dbg_req = 1'b0;
        check("t4_cpu_ack_cycle", cpu_n, 4);
        check("t4_dbg_ack_cycle", dbg_n, 9);
        check("t4_cpu_rdata", b_cpu_rdata, 32'hDEADBEEF);
        check("t4_dbg_rdata", b_dbg_rdata, 32'h12345678);

        // 5: reset during the ACCESS cycle of a write
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hAAAA5555;
        @(negedge clk);
        @(negedge clk);
        check("t5_ram_we_access", ram_we, 1);
        rst_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("t5_ram_we", ram_we, 0);
        check("t5_cpu_ack", cpu_ack, 0);
        check("t5_ram_addr", ram_addr, 0);
        check("t5_ram_wdata", ram_wdata, 0);
        check("t5_cpu_rdata", cpu_rdata, 0);
        check("t5_dbg_rdata", dbg_rdata, 0);
        check("t5_state", fsm_state, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a0 = cpu_ack_cnt;
        repeat (4) @(negedge clk);
        check("t5_no_late_ack", cpu_ack_cnt - a0, 0);

`ifdef MEM_ARB_LOCK_EN
        // 6: lock holds off the CPU while debug traffic proceeds
        @(posedge clk); #1;
        dbg_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        a0 = cpu_ack_cnt;
        for (int i = 0; i < 7; i++) begin
            do_access(1'b1, 1'b0, 32'h20, 32'h0, rd, lat);
            check("t6_dbg_rdata", rd, 32'h12345678);
        end
        @(negedge clk);
        check("t6_cpu_stall", cpu_stall, 1);
        check("t6_no_cpu_ack", cpu_ack_cnt - a0, 0);
        @(posedge clk); #1;
        dbg_lock = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 6 && !seen; n++) begin
            @(negedge clk);
            if (cpu_ack) seen = 1'b1;
        end
        check("t6_cpu_ack_after_unlock", {31'b0, seen}, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
